mux_out_filter: RTL and testbench
=================================

# mux_out_filter

Sequential stage directly downstream of the gate-level 2:1 multiplexer. It samples the mux output `z`, which can glitch when `sel` toggles because of the static hazard in the NAND-based path. It passes a level change through only after the level has been stable for a programmable number of clock cycles. It also emits one-cycle rise/fall pulses and counts rejected glitches for the bench and later stages.

## Interface
Parameters:
- `STABLE_CYCLES`, default 3: consecutive stable samples required before `dout` changes; legal range 1..255.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: stability-counter width; derived, never overridden.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `din` input 1: asynchronous mux output (`z`).
- `en` input 1: filter enable.
- `dout` output 1: filtered level.
- `rise` output 1: one-cycle pulse when `dout` goes 0→1.
- `fall` output 1: one-cycle pulse when `dout` goes 1→0.
- `glitch_cnt` output 8: rejected-glitch count, saturating.

## Operation
- **Input synchroniser.** `din` passes through two flops, `s1` then `s2`. The synchroniser runs regardless of `en`.
- **Stability counter.** `cnt` (`CNT_W` bits) counts consecutive cycles with `s2 != dout`.
- **Per rising edge, with `rst`=0 and `en`=1:**
  - If `s2 != dout` and `cnt == STABLE_CYCLES-1`: set `dout <= s2` and `cnt <= 0`. Assert `rise` if `s2`=1, otherwise assert `fall`.
  - If `s2 != dout` and `cnt < STABLE_CYCLES-1`: `cnt <= cnt+1`.
  - If `s2 == dout` and `cnt != 0`: this is a rejected glitch. Set `cnt <= 0` and increment `glitch_cnt`; it holds at 255 once reached.
  - If `s2 == dout` and `cnt == 0`: no change.
- **With `en`=0:**
  - `cnt <= 0`.
  - `dout` and `glitch_cnt` hold.
  - `rise`/`fall` are 0.
  - Clearing a pending count because of `en` is not a glitch.
- **`rise`/`fall`:** registered, asserted only in the cycle immediately after the update edge, never both at once.
- **`STABLE_CYCLES`=1:** `dout` follows `s2` one edge later. `glitch_cnt` never increments.
- **Input state machine:** implicit two-state FSM, IDLE (`cnt`=0) and PENDING (`cnt`>0). There is no third state.

## Timing
- Reset values: `s1`=`s2`=0, `cnt`=0, `dout`=0, `rise`=`fall`=0, `glitch_cnt`=0.
- `rst` asserted mid-count:
  - Everything returns to reset values at that edge.
  - A pending transition is dropped and is not counted as a glitch.
  - `rst` wins over `en`.
- Latency: `din` changes and then stays stable. `dout` changes on the (`STABLE_CYCLES`+2)th rising edge after the change, which is edge 5 for the default. The matching pulse is high for exactly that following cycle.
- Minimum accepted pulse width on `din` is `STABLE_CYCLES`+0 cycles as seen at `s2`. Shorter pulses, including sub-cycle mux hazards that happen to be sampled, are rejected and counted once each.
- Back-to-back transitions: the opposite transition begins counting on the edge after `dout` updates. Pulses can therefore occur at most once every `STABLE_CYCLES` cycles.
- Simultaneous events: an update edge and `glitch_cnt` saturation cannot coincide, since they occur in exclusive branches.
- Purely synchronous design: there are no gate-delay parameters in this block.

## Structure
- `mux_out_filter_pkg` holds:
  - `GLITCH_CNT_W` = 8;
  - `GLITCH_CNT_MAX` = 8'hFF;
  - `typedef enum logic {IDLE, PENDING} filt_state_t`.
- Sub-module `sync2`: a two-flop synchroniser with `clk`, `rst`, `d`, `q`. It is reused wherever mux outputs cross into clocked logic.
- Top-level contents: counter, update logic, pulse registers and saturating glitch counter. Target size is about 150 lines.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `din`=1 → all outputs 0. After release, with `en`=1 and `din` held at 1, `dout`=1 appears at edge 5 and `rise` is high for one cycle.
- **Glitch rejection:** `din` pulses 1 for 2 cycles from a stable 0 (`STABLE_CYCLES`=3) → `dout` stays 0, `glitch_cnt`=1, no pulses.
- **Fall path:** from `dout`=1, drive `din`=0 and hold → `fall` is high for exactly one cycle at edge 5; `glitch_cnt` is unchanged.
- **Enable and reset interruption:**
  - Start a 0→1 transition and drop `en` at `cnt`=1 → `cnt` clears, `dout` stays 0, `glitch_cnt` stays 0.
  - Re-enable → a full count restarts.
  - Assert `rst` mid-count → identical clear.
- **Saturation:** 300 two-cycle glitches → `glitch_cnt` reaches 255 and holds.
- **Live mux hazard:** instantiate the NAND mux upstream with `d0`=`d1`=1 and toggle `sel` every 4 cycles → `dout` stays 1 and never pulses.

Source files
------------

// File: rtl/mux_out_filter_pkg.sv
// Shared widths and state encoding for the mux output filter and its
// helpers.
package mux_out_filter_pkg;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

  typedef enum logic {IDLE, PENDING} filt_state_t;

endpackage

// File: rtl/mux_out_filter_sync2.sv
// Two-flop synchroniser used wherever a combinational mux output is
// brought into clocked logic.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/mux_out_filter.sv
// Debounce filter behind the NAND mux: a level must hold for STABLE_CYCLES
// synchronised samples before it reaches dout.
module mux_out_filter
  import mux_out_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    en,
  output logic                    dout,
  output logic                    rise,
  output logic                    fall,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(
    input logic [GLITCH_CNT_W-1:0] v
  );
    return (v == GLITCH_CNT_MAX) ? v : v + GLITCH_CNT_W'(1);
  endfunction

  logic                    s2;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dout_q, dout_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;
  filt_state_t             state;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s2)
  );

  assign state = (cnt_q != '0) ? PENDING : IDLE;

  // Stage boundary: synchronised sample -> counter / level / pulse update
  always_comb begin
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    if (en) begin
      if (s2 != dout_q) begin
        if (cnt_q == CNT_LAST) begin
          dout_d = s2;
          cnt_d  = '0;
          rise_d = s2;
          fall_d = ~s2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (state == PENDING) begin
        // Level fell back before qualifying: drop it and count the glitch.
        cnt_d    = '0;
        glitch_d = sat_inc(glitch_q);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_mux_out_filter.sv
// Bench for mux_out_filter: expected rise/fall events are queued with their
// due cycle when stimulus is applied and matched as the pulses appear.
module tb_mux_out_filter;

  localparam int SC = 3;

  typedef struct {
    bit is_rise;
    int cyc;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_drv;
  logic       en;
  logic       dout;
  logic       rise;
  logic       fall;
  logic [7:0] glitch_cnt;

  // Behavioural NAND mux upstream, with the inverted select arriving late.
  logic use_mux;
  logic sel;
  logic nsel;
  logic d0;
  logic d1;
  logic na;
  logic nb;
  logic z;

  int     cyc   = 0;
  int     total = 0;
  int     bad   = 0;
  pulse_t exp_q[$];

  mux_out_filter #(.STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .en         (en),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always begin
    @(sel);
    #2;
    nsel = ~sel;
  end

  always_comb begin
    na  = ~(d1 & sel);
    nb  = ~(d0 & nsel);
    z   = ~(na & nb);
    din = use_mux ? z : din_drv;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input bit is_rise, input int due);
    pulse_t p;
    p.is_rise = is_rise;
    p.cyc     = due;
    exp_q.push_back(p);
  endtask

  // Scoreboard: every observed pulse must match the oldest queued event.
  always @(negedge clk) begin
    if (!rst && (rise || fall)) begin
      pulse_t p;
      check("pulse_exclusive", int'(rise && fall), 0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", int'(rise), 0);
        check("spurious_pulse_f", int'(fall), 0);
      end else begin
        p = exp_q.pop_front();
        check("pulse_kind_rise", int'(rise), int'(p.is_rise));
        check("pulse_cycle", cyc, p.cyc);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    din_drv = 1'b1;
    use_mux = 1'b0;
    sel     = 1'b0;
    nsel    = 1'b1;
    d0      = 1'b1;
    d1      = 1'b1;

    // Reset with din high, then release and expect the rise at edge 5.
    tick(2);
    check("rst_dout", int'(dout), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_glitch", int'(glitch_cnt), 0);
    rst = 1'b0;
    expect_pulse(1'b1, cyc + SC + 2);
    tick(8);
    check("rise_dout", int'(dout), 1);

    // Fall path.
    din_drv = 1'b0;
    expect_pulse(1'b0, cyc + SC + 2);
    tick(8);
    check("fall_dout", int'(dout), 0);
    check("fall_glitch", int'(glitch_cnt), 0);

    // Two-cycle pulse is rejected and counted once.
    din_drv = 1'b1;
    tick(2);
    din_drv = 1'b0;
    tick(6);
    check("glitch_dout", int'(dout), 0);
    check("glitch_cnt1", int'(glitch_cnt), 1);

    // Drop enable mid-count, then restart a full count.
    din_drv = 1'b1;
    tick(3);
    en = 1'b0;
    tick(4);
    check("en_off_dout", int'(dout), 0);
    check("en_off_glitch", int'(glitch_cnt), 1);
    en = 1'b1;
    expect_pulse(1'b1, cyc + SC);
    tick(6);
    check("en_on_dout", int'(dout), 1);
    check("en_on_glitch", int'(glitch_cnt), 1);

    // Reset mid-count drops the pending fall.
    din_drv = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    check("rstmid_dout", int'(dout), 0);
    check("rstmid_glitch", int'(glitch_cnt), 0);

    // Saturation of the glitch counter.
    for (int i = 0; i < 300; i++) begin
      din_drv = 1'b1;
      tick(2);
      din_drv = 1'b0;
      tick(4);
      if (i == 253) check("sat_254", int'(glitch_cnt), 254);
      if (i == 254) check("sat_255", int'(glitch_cnt), 255);
    end
    check("sat_hold", int'(glitch_cnt), 255);
    check("sat_dout", int'(dout), 0);

    // Live NAND mux with d0=d1=1: select toggles must never reach dout.
    use_mux = 1'b1;
    rst     = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_pulse(1'b1, cyc + SC + 2);
    tick(8);
    check("mux_dout_up", int'(dout), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #9;
      sel = ~sel;
      repeat (3) @(posedge clk);
    end
    tick(8);
    check("mux_dout_hold", int'(dout), 1);
    check("mux_glitches", int'(glitch_cnt), 5);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
